// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: requester count,
// index/counter widths and the FSM state encoding.
package fifo_arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin winner selection: first set request bit searched upward from
// (ptr+1) mod NREQ, wrapping around so that ptr itself is examined last.
module rr_pick
    import fifo_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] win_oh,
    output logic [1:0] win_idx
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan the requesters in rotated priority order; the first hit wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Four-requester burst arbiter feeding a FIFO write port. A grant lasts up
// to BURST_LEN accepted words, stalls on fifo_full and ends early when the
// granted requester drops its request. Bursts are separated by one IDLE cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   data_in,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [DATA_W-1:0]     wr_data,
    output logic [3:0]            gnt,
    output logic [3:0]            ack,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // ptr_q doubles as the index of the active grant while in XFER.
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [3:0]       win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             req_g;

    rr_pick u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    // State, grant, burst counter and priority pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic and write-port outputs derived from the registered grant.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_data = '0;
        ack     = '0;
        req_g   = req[ptr_q];

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = XFER;
                    gnt_d   = win_oh;
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                wr_en   = req_g & ~fifo_full;
                wr_data = data_in[ptr_q*DATA_W +: DATA_W];
                if (wr_en) begin
                    ack   = gnt_q;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!req_g || (wr_en && (cnt_q == LAST_CNT))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
        endcase
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == XFER);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: BURST_LEN=4 instance for the main
// scenarios, BURST_LEN=1 instance for single-word alternation.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst,  rst1;
    logic [3:0]  req,  req1;
    logic [31:0] data_in;
    logic        fifo_full, fifo_full1;
    logic        wr_en, wr_en1;
    logic [7:0]  wr_data, wr_data1;
    logic [3:0]  gnt, gnt1, ack, ack1;
    logic        busy, busy1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fifo_wr_arbiter #(.DATA_W(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
        .gnt(gnt), .ack(ack), .busy(busy)
    );

    fifo_wr_arbiter #(.DATA_W(8), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst1), .req(req1), .data_in(data_in),
        .fifo_full(fifo_full1), .wr_en(wr_en1), .wr_data(wr_data1),
        .gnt(gnt1), .ack(ack1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slice(input int unsigned w);
        return 8'h10 + 8'(w) * 8'h11;
    endfunction

    task automatic exp_main(input string tag, input logic [3:0] eg, input logic ew,
                            input logic [7:0] ed, input logic eb);
        #1;
        check({tag, ".gnt"},     32'(gnt),     32'(eg));
        check({tag, ".wr_en"},   32'(wr_en),   32'(ew));
        check({tag, ".ack"},     32'(ack),     ew ? 32'(eg) : 32'd0);
        check({tag, ".wr_data"}, 32'(wr_data), 32'(ed));
        check({tag, ".busy"},    32'(busy),    32'(eb));
    endtask

    task automatic exp_one(input string tag, input logic [3:0] eg, input logic ew,
                           input logic [7:0] ed, input logic eb);
        #1;
        check({tag, ".gnt"},     32'(gnt1),     32'(eg));
        check({tag, ".wr_en"},   32'(wr_en1),   32'(ew));
        check({tag, ".ack"},     32'(ack1),     ew ? 32'(eg) : 32'd0);
        check({tag, ".wr_data"}, 32'(wr_data1), 32'(ed));
        check({tag, ".busy"},    32'(busy1),    32'(eb));
    endtask

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        req = '0;   req1 = '0;
        fifo_full = 1'b0; fifo_full1 = 1'b0;
        data_in = {8'h43, 8'h32, 8'h21, 8'h10};

        cyc(); cyc();
        exp_main("reset", 4'h0, 1'b0, 8'h00, 1'b0);

        // Single requester: 4-word burst, one IDLE cycle, regrant to itself.
        cyc();
        rst = 1'b0; req = 4'b0001;
        exp_main("t29.idle0", 4'h0, 1'b0, 8'h00, 1'b0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            exp_main($sformatf("t29.w%0d", i), 4'b0001, 1'b1, slice(0), 1'b1);
            cyc();
        end
        exp_main("t29.gap", 4'h0, 1'b0, 8'h00, 1'b0);
        cyc();
        req = 4'b0000;
        exp_main("t29.regrant", 4'b0001, 1'b0, slice(0), 1'b1);
        cyc();
        exp_main("t29.end", 4'h0, 1'b0, 8'h00, 1'b0);

        // All requesting: order 0,1,2,3,0 from a fresh reset.
        rst = 1'b1;
        cyc();
        rst = 1'b0; req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            exp_main($sformatf("t30.b%0d.idle", b), 4'h0, 1'b0, 8'h00, 1'b0);
            cyc();
            for (int k = 0; k < 4; k++) begin
                exp_main($sformatf("t30.b%0d.w%0d", b, k), 4'(1 << (b % 4)), 1'b1,
                         slice(b % 4), 1'b1);
                cyc();
            end
        end

        // Stall on fifo_full for 3 cycles after word 2 (ptr=0 -> winner 2).
        req = 4'b0100;
        exp_main("t31.idle", 4'h0, 1'b0, 8'h00, 1'b0);
        cyc();
        exp_main("t31.w1", 4'b0100, 1'b1, slice(2), 1'b1);
        cyc();
        exp_main("t31.w2", 4'b0100, 1'b1, slice(2), 1'b1);
        cyc();
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            exp_main($sformatf("t31.stall%0d", s), 4'b0100, 1'b0, slice(2), 1'b1);
            cyc();
        end
        fifo_full = 1'b0;
        exp_main("t31.w3", 4'b0100, 1'b1, slice(2), 1'b1);
        cyc();
        exp_main("t31.w4", 4'b0100, 1'b1, slice(2), 1'b1);
        cyc();

        // Requester 1 drops after 2 words (ptr=2 -> winner 1).
        req = 4'b0010;
        exp_main("t31.after", 4'h0, 1'b0, 8'h00, 1'b0);
        cyc();
        exp_main("t32.w1", 4'b0010, 1'b1, slice(1), 1'b1);
        cyc();
        exp_main("t32.w2", 4'b0010, 1'b1, slice(1), 1'b1);
        cyc();
        req = 4'b0000;
        exp_main("t32.drop", 4'b0010, 1'b0, slice(1), 1'b1);
        cyc();
        exp_main("t32.end", 4'h0, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-burst, then arbitration restarts from ptr=3.
        req = 4'b0100;
        cyc();
        exp_main("t33.w1", 4'b0100, 1'b1, slice(2), 1'b1);
        cyc();
        rst = 1'b1;
        exp_main("t33.async", 4'h0, 1'b0, 8'h00, 1'b0);
        req = 4'b1100;
        cyc();
        rst = 1'b0;
        exp_main("t33.idle", 4'h0, 1'b0, 8'h00, 1'b0);
        cyc();
        exp_main("t33.regrant", 4'b0100, 1'b1, slice(2), 1'b1);
        req = 4'b0000;
        cyc();
        exp_main("t33.end", 4'h0, 1'b0, 8'h00, 1'b0);

        // BURST_LEN=1: single-word bursts alternating 1,3,1,3.
        rst1 = 1'b0; req1 = 4'b1010;
        for (int b = 0; b < 4; b++) begin
            int unsigned w;
            w = (b % 2 == 0) ? 1 : 3;
            exp_one($sformatf("t34.b%0d.idle", b), 4'h0, 1'b0, 8'h00, 1'b0);
            cyc();
            exp_one($sformatf("t34.b%0d.w", b), 4'(1 << w), 1'b1, slice(w), 1'b1);
            cyc();
        end
        exp_one("t34.end", 4'h0, 1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, data width per requester and FIFO write port.
REQ-002 Parameter: BURST_LEN, default 4, max words per grant; legal range 1..15.
REQ-003 Port: clk  input  1  single clock, equal to the FIFO write-side clock.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  4  per-requester write request; bit i = requester i.
REQ-006 Port: data_in  input  4*DATA_W  packed data; requester i at [DATA_W*i +: DATA_W].
REQ-007 Port: fifo_full  input  1  FIFO full flag from the write unit.
REQ-008 Port: wr_en  output  1  FIFO write enable.
REQ-009 Port: wr_data  output  DATA_W  FIFO write data.
REQ-010 Port: gnt  output  4  one-hot grant, all-zero when idle.
REQ-011 Port: ack  output  4  per-requester pulse; word accepted this cycle.
REQ-012 Port: busy  output  1  high while a burst is in progress.

Function
REQ-013 FSM SHALL have two states: IDLE and XFER; the state, gnt, burst counter and round-robin pointer SHALL be registered.
REQ-014 IDLE -> XFER at the next edge when req != 0; gnt loads the winner; the burst counter clears to 0.
REQ-015 Winner SHALL be the first set req bit searched from (ptr+1) mod 4 upward, wrapping; ptr loads the winner index on grant.
REQ-016 In XFER: wr_en = req[g] & ~fifo_full, combinational from registered gnt; wr_data = data_in slice g; ack[g] = wr_en; other ack bits 0.
REQ-017 Each cycle with wr_en=1 SHALL increment the burst counter by 1; the counter is 4 bits wide.
REQ-018 XFER -> IDLE at the edge where wr_en=1 and counter = BURST_LEN-1, or where req[g]=0; gnt clears to 0 at that edge.
REQ-019 fifo_full=1 in XFER SHALL stall: wr_en=0, grant held, counter unchanged; there is no timeout.
REQ-020 If req[g] drops mid-burst, no write occurs that cycle and the burst ends at the next edge.
REQ-021 One IDLE cycle SHALL separate consecutive bursts; the same requester may win again only when no other req is set.
REQ-022 In IDLE: wr_en=0, ack=0, wr_data=0.
REQ-023 busy = (state == XFER).
REQ-024 Changes to req bits other than g during XFER SHALL NOT affect the current burst.

Reset
REQ-025 rst=1 SHALL force immediately, asynchronously: state=IDLE, gnt=0, counter=0, ptr=3 (requester 0 first priority), busy=0, wr_en=0, ack=0.
REQ-026 Reset asserted mid-burst SHALL abort the burst with no further write; after release, arbitration restarts from ptr=3.

Structure
REQ-027 Shared package fifo_arb_pkg SHALL hold the state encoding (IDLE=0, XFER=1), the requester count NREQ=4, and the counter width.
REQ-028 A combinational sub-module rr_pick (inputs: req, ptr; output: one-hot winner and index) SHALL implement REQ-015.

Verification
REQ-029 Reset released, req=0001, fifo_full=0, BURST_LEN=4 -> gnt=0001 one cycle later; 4 consecutive wr_en with ack[0]; then 1 IDLE cycle; then regrant to 0.
REQ-030 req=1111 held, fifo_full=0 -> grant order 0,1,2,3,0; each burst 4 words; wr_data matches the granted slice on every write.
REQ-031 req=0100 in burst, fifo_full=1 for 3 cycles after word 2 -> wr_en=0 for those 3 cycles, gnt held, words 3-4 follow, 4 words total.
REQ-032 req=0010 dropped after 2 words -> exactly 2 acks, gnt=0000 next cycle, busy=0.
REQ-033 rst pulsed after word 1 of burst to requester 2 -> gnt/wr_en/busy go 0 with no clock edge; after release with req=1100 -> requester 2 granted first (ptr=3).
REQ-034 BURST_LEN=1, req=1010 -> alternating single-word bursts 1,3,1,3 separated by single IDLE cycles.
